seg7_number_display: RTL and testbench
======================================

# seg7_number_display

Parametrised N-digit multiplexed 7-segment number display driver. Accepts a binary value with a load strobe and converts it to decimal with a sequential double-dabble converter, or shows it directly as hex. It drives a time-multiplexed common-segment display with a built-in scan prescaler, per-digit decimal points, leading-zero blanking and an overflow indication. It sits between status/counter logic and the board's 7-segment pins, and supersedes fixed 3-digit display use.

## Interface
- `DIGITS`, 3: number of display digits (≥1).
- `NUM_W`, 10: width of the binary input value.
- `SCAN_DIV`, 50000: clock cycles each digit is lit (≥2).
- `SEG_ACTIVE_LOW`, 1: 1 inverts `seg` (pin low = segment lit).
- `DIG_ACTIVE_LOW`, 0: 1 inverts `dig`.
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `num`  in  NUM_W: value to display; sampled when `num_valid` is accepted.
- `num_valid`  in  1: load strobe; accepted only when `busy`=0.
- `hex_mode`  in  1: 1 = hex digits, 0 = decimal; sampled with `num`.
- `dp`  in  DIGITS: decimal-point enables, bit i → digit i; sampled with `num`.
- `blank_lz`  in  1: leading-zero blanking enable; live input, not sampled.
- `seg`  out  8: segments; bit0=a … bit6=g, bit7=dp.
- `dig`  out  DIGITS: one-hot digit enable; bit 0 = most-significant (leftmost) digit.
- `busy`  out  1: conversion in progress.
- `overflow`  out  1: the last accepted value does not fit in DIGITS digits.

## Operation
- **State machine:** IDLE → CONV → IDLE.
  - In IDLE, an accepted `num_valid` latches `num`, `hex_mode` and `dp`.
    - Decimal: go to CONV.
    - Hex: nibbles load directly and the block spends exactly one cycle in CONV.
  - CONV (decimal) runs `NUM_W` double-dabble iterations. Each iteration adds 3 to every BCD nibble ≥5, then shifts the whole register left by 1.
  - The shift register is `NUM_W + 4*DIGITS` bits wide.
  - On the last iteration, the digit registers, dp register and `overflow` update together atomically. The display never shows a partial result.
- **Overflow:**
  - Decimal: latched value ≥ 10^DIGITS. If 10^DIGITS > 2^NUM_W − 1, overflow never occurs.
  - Hex: value ≥ 16^DIGITS.
  - While `overflow`=1, every digit shows a dash (g only). The dp bits still apply.
- **Leading-zero blanking** (when `blank_lz`=1): zero digits left of the first non-zero digit show blank. The rightmost digit is always shown. No blanking is applied while `overflow`=1.
- **Glyphs:** 0–9 and A–F use standard patterns (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71). Blank=0x00, dash=0x40. The dp bit is ORed into bit7.
- **Scan:**
  - The prescaler counts 0..SCAN_DIV−1 and wraps.
  - At its terminal count, the digit index advances 0..DIGITS−1 and wraps to 0.
  - Scanning runs continuously, independent of `busy`.
- `num_valid` while `busy`=1 is ignored, including on the final CONV cycle. There is no queueing.
- **Reset:**
  - Clears the FSM to IDLE, prescaler to 0, digit index to 0, digit values to 0, dp register to 0 and `overflow` to 0.
  - Reset mid-conversion aborts it, and the displayed value reverts to 0.

## Timing
- **Reset values:**
  - `seg` = all segments off (0xFF when SEG_ACTIVE_LOW=1).
  - `dig` = all off (0 when DIG_ACTIVE_LOW=0).
  - `busy` = 0, `overflow` = 0.
- **Decimal latency:** `num_valid` accepted at edge T → `busy`=1 from T+1 through T+NUM_W. New digits are in the registers at T+NUM_W, `busy`=0 at T+NUM_W+1.
- **Hex latency:** `busy`=1 for one cycle only, at T+1.
- **Registered outputs:** `seg` and `dig` are registered from the digit index and digit registers, giving 1 cycle of latency. They change only on a prescaler wrap or a digit/dp/overflow register update.
- Exactly one `dig` bit is active at all times after the first post-reset cycle.

## Structure
- **Package `seg7_pkg`:**
  - Constants `SEG_BLANK` (0x00) and `SEG_DASH` (0x40).
  - Function `seg7_glyph(nibble)` → 7-bit pattern.
- **Sub-module `seg7_bin2bcd`:**
  - Parameters `NUM_W`, `DIGITS`.
  - Ports `start`, `bin`, `busy`, `done`, `bcd`.
  - Holds the sequential double-dabble converter.
- Top level holds the hex bypass, overflow compare, blanking, prescaler and scan registers.

## Test plan
All scenarios use DIGITS=3, NUM_W=10, SCAN_DIV=4, active-low segments, active-high digits.
- **Reset:** hold `rst` → `seg`=0xFF, `dig`=000, `busy`=0. After release with `blank_lz`=1, digits show blank, blank, "0" (`seg`=0xC0 on `dig`=100). Each digit is lit for 4 cycles.
- **Decimal, no blanking:** `num`=123, `blank_lz`=0 → `busy` high for 10 cycles. Then `dig`=001/010/100 show `seg`=0xF9/0xA4/0xB0.
- **Blanking and dp:** `num`=7, `blank_lz`=1, `dp`=100 → digits show 0xFF, 0xFF, 0x78 (7 with dp).
- **Overflow:** `num`=1000 → `overflow`=1, and every digit shows `seg`=0xBF. A following load of `num`=999 clears `overflow`.
- **Hex and ignored load:** `hex_mode`=1, `num`=0x2AF → `busy` for 1 cycle, digits show 0xA4/0x88/0x8E. A `num_valid` pulsed during a decimal conversion is ignored.
- **Reset mid-conversion:** assert `rst` during CONV → `busy`=0 next cycle, display shows 0, and the next load converts correctly.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, segment constants and helpers for the multiplexed 7-segment display driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seg7_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}; dp is handled separately as bit 7.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // 10^n, saturating at all-ones so large digit counts never wrap and
    // simply make the decimal overflow compare unreachable.
    function automatic logic [63:0] pow10_sat(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            if (p > (64'hFFFF_FFFF_FFFF_FFFF / 64'd10)) begin
                p = 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
                p = p * 64'd10;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per cycle.
// Latency: start at edge T -> done high during the cycle ending at edge T+NUM_W; bcd is valid while done=1.
// Backpressure: none; start is only honoured when idle, the caller must hold off while busy.
// Ports: clk/rst (sync active-high), start+bin load, busy, done (combinational, final iteration),
//        bcd = result of the final iteration, DIGITS nibbles, least-significant digit in bits [3:0].
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int NUM_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int SR_W  = NUM_W + 4 * DIGITS;
    localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_W - 1);

    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // One iteration: add 3 to every BCD nibble >= 5, then shift left by one.
    always_comb begin
        logic [SR_W-1:0] adj;
        adj = sr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (sr_q[NUM_W + 4*k +: 4] >= 4'd5) begin
                adj[NUM_W + 4*k +: 4] = sr_q[NUM_W + 4*k +: 4] + 4'd3;
            end
        end
        sr_d = {adj[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            sr_q   <= SR_W'(bin);
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LAST);
    // Taken from the next-state value so the caller can capture the result on
    // the same edge as the final iteration.
    assign bcd  = sr_d[SR_W-1 -: 4*DIGITS];

endmodule

// File: rtl/seg7_number_display.sv
// N-digit multiplexed 7-segment number driver: decimal (double-dabble) or hex, LZ blanking, overflow dashes.
// Latency: decimal load -> new digits after NUM_W cycles, hex after 1 cycle; seg/dig registered, +1 cycle.
// Backpressure: num_valid is accepted only while busy=0; loads during a conversion are dropped, no queueing.
// Ports: clk/rst (sync active-high); num/num_valid/hex_mode/dp load interface; blank_lz live;
//        seg {dp,g..a}, dig one-hot (bit 0 = leftmost digit), busy, overflow.
module seg7_number_display
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int NUM_W          = 10,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_W-1:0]    num,
    input  logic                num_valid,
    input  logic                hex_mode,
    input  logic [DIGITS-1:0]   dp,
    input  logic                blank_lz,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   dig,
    output logic                busy,
    output logic                overflow
);

    localparam int EXT_W = (NUM_W > 4*DIGITS) ? NUM_W : 4*DIGITS;
    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0]       DEC_LIMIT = pow10_sat(DIGITS);
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    // ---------------- load / convert control ----------------
    state_t              state_q, state_d;
    logic [NUM_W-1:0]    num_q;
    logic                hex_q;
    logic [DIGITS-1:0]   dp_in_q;

    // Displayed state; index 0 is the leftmost (most-significant) digit.
    logic [3:0]          digit_q [DIGITS];
    logic [3:0]          digit_d [DIGITS];
    logic [DIGITS-1:0]   dp_q;
    logic                ovf_q, ovf_d;
    logic                upd;

    logic                accept;
    logic                conv_busy, conv_done;
    logic [4*DIGITS-1:0] conv_bcd;
    logic [EXT_W-1:0]    num_ext;

    assign accept  = num_valid && (state_q == ST_IDLE);
    assign num_ext = EXT_W'(num_q);

    seg7_bin2bcd #(
        .NUM_W  (NUM_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept && !hex_mode),
        .bin   (num),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_d = state_q;
        upd     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (hex_q || conv_done) begin
                    state_d = ST_IDLE;
                    upd     = 1'b1;
                end else if (!conv_busy) begin
                    // Converter idle without a result: never strand the FSM.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Candidate display contents, committed only on upd so digits, dp and
    // overflow always change together.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            digit_d[i] = hex_q ? num_ext[4*(DIGITS-1-i) +: 4]
                               : conv_bcd[4*(DIGITS-1-i) +: 4];
        end
        if (hex_q) begin
            ovf_d = (num_ext >> (4*DIGITS)) != '0;
        end else begin
            ovf_d = (64'(num_q) >= DEC_LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            hex_q   <= 1'b0;
            dp_in_q <= '0;
            dp_q    <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                digit_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                num_q   <= num;
                hex_q   <= hex_mode;
                dp_in_q <= dp;
            end
            if (upd) begin
                dp_q  <= dp_in_q;
                ovf_q <= ovf_d;
                for (int i = 0; i < DIGITS; i++) begin
                    digit_q[i] <= digit_d[i];
                end
            end
        end
    end

    // ---------------- scan and segment generation ----------------
    logic [PS_W-1:0]   ps_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        seg_q, seg_raw;
    logic [DIGITS-1:0] dig_q, dig_raw;
    logic [DIGITS-1:0] blank;

    // A digit is blank when it and everything to its left is zero; the
    // rightmost digit is always shown and dashes take priority.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            zero_run = zero_run && (digit_q[i] == 4'd0);
            blank[i] = blank_lz && !ovf_q && zero_run && (i != DIGITS - 1);
        end
    end

    always_comb begin
        seg_raw = {1'b0, SEG_BLANK};
        dig_raw = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_raw[i] = 1'b1;
                if (ovf_q) begin
                    seg_raw = {dp_q[i], SEG_DASH};
                end else if (blank[i]) begin
                    seg_raw = {dp_q[i], SEG_BLANK};
                end else begin
                    seg_raw = {dp_q[i], seg7_glyph(digit_q[i])};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q  <= '0;
            idx_q <= '0;
            seg_q <= SEG_OFF;
            dig_q <= DIG_OFF;
        end else begin
            if (ps_q == PS_LAST) begin
                ps_q  <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                ps_q <= ps_q + 1'b1;
            end
            seg_q <= (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            dig_q <= (DIG_ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;
        end
    end

    assign seg      = seg_q;
    assign dig      = dig_q;
    assign busy     = (state_q == ST_CONV);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_number_display.sv
// Directed self-checking bench for seg7_number_display (3 digits, 10-bit input, scan divider 4).
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_number_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] num = '0;
    logic       num_valid = 1'b0;
    logic       hex_mode = 1'b0;
    logic [2:0] dp = '0;
    logic       blank_lz = 1'b0;
    logic [7:0] seg;
    logic [2:0] dig;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_number_display #(
        .DIGITS         (3),
        .NUM_W          (10),
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .num_valid (num_valid),
        .hex_mode  (hex_mode),
        .dp        (dp),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dig       (dig),
        .busy      (busy),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until digit position pos is lit, then compare its segments.
    task automatic expect_digit(input string tag, input int pos, input logic [7:0] exp);
        logic [2:0] want;
        int k;
        want = 3'b001 << pos;
        k = 0;
        while (dig !== want && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (dig !== want) chk({tag, "_dig_timeout"}, {29'd0, dig}, {29'd0, want});
        else              chk(tag, {24'd0, seg}, {24'd0, exp});
    endtask

    task automatic load(input logic [9:0] v, input logic hx, input logic [2:0] d);
        @(negedge clk);
        num       = v;
        hex_mode  = hx;
        dp        = d;
        num_valid = 1'b1;
        @(posedge clk);
        #1 num_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_dig", {29'd0, dig}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_ovf", {31'd0, overflow}, 32'h0);

        // ---- post-reset display with blanking: blank, blank, 0 ----
        blank_lz = 1'b1;
        rst = 1'b0;
        expect_digit("rst_d0", 0, 8'hFF);
        expect_digit("rst_d1", 1, 8'hFF);
        expect_digit("rst_d2", 2, 8'hC0);
        expect_digit("lit_sync", 1, 8'hFF);
        n = 0;
        while (dig === 3'b010 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("lit_cycles", n, 4);

        // ---- decimal 123, no blanking ----
        blank_lz = 1'b0;
        load(10'd123, 1'b0, 3'b000);
        count_busy(n);
        chk("dec123_busy", n, 10);
        chk("dec123_ovf", {31'd0, overflow}, 0);
        repeat (2) @(negedge clk);
        expect_digit("dec123_d0", 0, 8'hF9);
        expect_digit("dec123_d1", 1, 8'hA4);
        expect_digit("dec123_d2", 2, 8'hB0);

        // ---- blanking and decimal point ----
        blank_lz = 1'b1;
        load(10'd7, 1'b0, 3'b100);
        count_busy(n);
        repeat (2) @(negedge clk);
        expect_digit("lz7_d0", 0, 8'hFF);
        expect_digit("lz7_d1", 1, 8'hFF);
        expect_digit("lz7_d2", 2, 8'h78);

        // ---- overflow, then cleared by 999 ----
        load(10'd1000, 1'b0, 3'b000);
        count_busy(n);
        chk("ovf_flag", {31'd0, overflow}, 1);
        repeat (2) @(negedge clk);
        expect_digit("ovf_d0", 0, 8'hBF);
        expect_digit("ovf_d1", 1, 8'hBF);
        expect_digit("ovf_d2", 2, 8'hBF);
        load(10'd999, 1'b0, 3'b000);
        count_busy(n);
        chk("ovf_clear", {31'd0, overflow}, 0);
        repeat (2) @(negedge clk);
        expect_digit("d999_d0", 0, 8'h90);
        expect_digit("d999_d2", 2, 8'h90);

        // ---- hex ----
        blank_lz = 1'b0;
        load(10'h2AF, 1'b1, 3'b000);
        count_busy(n);
        chk("hex_busy", n, 1);
        chk("hex_ovf", {31'd0, overflow}, 0);
        repeat (2) @(negedge clk);
        expect_digit("hex_d0", 0, 8'hA4);
        expect_digit("hex_d1", 1, 8'h88);
        expect_digit("hex_d2", 2, 8'h8E);

        // ---- loads during a conversion (mid and final cycle) are ignored ----
        load(10'd45, 1'b0, 3'b000);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 3 || n == 10) begin
                num = 10'd999;
                num_valid = 1'b1;
            end else begin
                num_valid = 1'b0;
            end
            @(negedge clk);
        end
        num_valid = 1'b0;
        chk("ign_busy", n, 10);
        repeat (2) @(negedge clk);
        chk("ign_idle", {31'd0, busy}, 0);
        expect_digit("ign_d0", 0, 8'hC0);
        expect_digit("ign_d1", 1, 8'h99);
        expect_digit("ign_d2", 2, 8'h92);

        // ---- reset mid-conversion ----
        load(10'd456, 1'b0, 3'b000);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_digit("midrst_d0", 0, 8'hC0);
        expect_digit("midrst_d1", 1, 8'hC0);
        expect_digit("midrst_d2", 2, 8'hC0);
        load(10'd321, 1'b0, 3'b000);
        count_busy(n);
        chk("after_rst_busy", n, 10);
        repeat (2) @(negedge clk);
        expect_digit("d321_d0", 0, 8'hB0);
        expect_digit("d321_d1", 1, 8'hA4);
        expect_digit("d321_d2", 2, 8'hF9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
